// File: rtl/addr_gen_if.sv
// addr_gen_if: job/config and address-stream bundle for addr_gen_seq.
// ADDR_GEN_SEQ_PERF_EN adds the stall_cnt/issue_cnt performance outputs.
interface addr_gen_if #(parameter int W = 16) ();
    logic         start;
    logic         abort;
    logic [W-1:0] cfg_offset;
    logic [W-1:0] cfg_x_max;
    logic [W-1:0] cfg_x_stride;
    logic [W-1:0] cfg_y_max;
    logic [W-1:0] cfg_y_stride;
    logic [W-1:0] addr_out;
    logic         addr_valid;
    logic         addr_ready;
    logic         addr_last;
    logic         busy;
    logic         done;
`ifdef ADDR_GEN_SEQ_PERF_EN
    logic [W-1:0] stall_cnt;
    logic [W-1:0] issue_cnt;
    modport master (
        output start, abort, cfg_offset, cfg_x_max, cfg_x_stride, cfg_y_max, cfg_y_stride, addr_ready,
        input  addr_out, addr_valid, addr_last, busy, done, stall_cnt, issue_cnt
    );
    modport slave (
        input  start, abort, cfg_offset, cfg_x_max, cfg_x_stride, cfg_y_max, cfg_y_stride, addr_ready,
        output addr_out, addr_valid, addr_last, busy, done, stall_cnt, issue_cnt
    );
`else
    modport master (
        output start, abort, cfg_offset, cfg_x_max, cfg_x_stride, cfg_y_max, cfg_y_stride, addr_ready,
        input  addr_out, addr_valid, addr_last, busy, done
    );
    modport slave (
        input  start, abort, cfg_offset, cfg_x_max, cfg_x_stride, cfg_y_max, cfg_y_stride, addr_ready,
        output addr_out, addr_valid, addr_last, busy, done
    );
`endif
endinterface

// File: rtl/addr_gen_seq.sv
// addr_gen_seq: nested 2-D affine address sequencer (addr = offset + x*xs + y*ys, x fastest).
// Optional ADDR_GEN_SEQ_PERF_EN adds saturating stall/issue counters.
module addr_gen_seq #(
    parameter int W = 16
) (
    input logic        clk,
    input logic        rst_n,
    addr_gen_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [W-1:0] ONE = W'(1);

    logic [1:0]   state;
    logic [W-1:0] x, y, x_max, x_stride, y_max, y_stride, row_base, addr;
    logic         valid, last;
    logic         hs, go, x_end, y_end;
    logic [W-1:0] x_nx, y_nx;

    assign hs    = valid && bus.addr_ready;
    assign go    = state == IDLE && bus.start && !bus.abort;
    assign x_end = x == x_max - ONE;
    assign y_end = y == y_max - ONE;
    assign x_nx  = x + ONE;
    assign y_nx  = y + ONE;

    // row_base tracks the first address of the current row so a row wrap
    // needs only one add instead of undoing the inner-loop strides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            x_max    <= '0;
            x_stride <= '0;
            y_max    <= '0;
            y_stride <= '0;
            row_base <= '0;
            addr     <= '0;
            valid    <= 1'b0;
            last     <= 1'b0;
        end else if (bus.abort && state != IDLE) begin
            state <= IDLE;
            valid <= 1'b0;
            last  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    x_max    <= bus.cfg_x_max;
                    x_stride <= bus.cfg_x_stride;
                    y_max    <= bus.cfg_y_max;
                    y_stride <= bus.cfg_y_stride;
                    x        <= '0;
                    y        <= '0;
                    addr     <= bus.cfg_offset;
                    row_base <= bus.cfg_offset;
                    state    <= (bus.cfg_x_max == '0 || bus.cfg_y_max == '0) ? DONE : RUN;
                    valid    <= bus.cfg_x_max != '0 && bus.cfg_y_max != '0;
                    last     <= bus.cfg_x_max == ONE && bus.cfg_y_max == ONE;
                end
                RUN: if (hs) begin
                    if (!x_end) begin
                        x    <= x_nx;
                        addr <= addr + x_stride;
                        last <= x_nx == x_max - ONE && y_end;
                    end else if (!y_end) begin
                        x        <= '0;
                        y        <= y_nx;
                        addr     <= row_base + y_stride;
                        row_base <= row_base + y_stride;
                        last     <= x_max == ONE && y_nx == y_max - ONE;
                    end else begin
                        valid <= 1'b0;
                        last  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr_out   = addr;
    assign bus.addr_valid = valid;
    assign bus.addr_last  = last;
    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DONE;

`ifdef ADDR_GEN_SEQ_PERF_EN
    logic [W-1:0] stall_cnt, issue_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            issue_cnt <= '0;
        end else if (go) begin
            stall_cnt <= '0;
            issue_cnt <= '0;
        end else begin
            if (state == RUN && valid && !bus.addr_ready && stall_cnt != '1) stall_cnt <= stall_cnt + ONE;
            if (state == RUN && hs && issue_cnt != '1) issue_cnt <= issue_cnt + ONE;
        end
    end
    assign bus.stall_cnt = stall_cnt;
    assign bus.issue_cnt = issue_cnt;
`endif
endmodule

// File: tb/tb_addr_gen_seq.sv
// tb_addr_gen_seq: table-driven jobs with an address scoreboard plus abort/reset sequences.
module tb_addr_gen_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addr_gen_if #(.W(16)) bus ();
    addr_gen_seq #(.W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [15:0] off, xm, xs, ym, ys;
        int          mode;
        int          exp_n;
    } vec_t;
    typedef struct {
        logic [15:0] a;
        logic        l;
    } exp_t;

    vec_t vecs[8];
    exp_t q[$];
    int checks = 0, errors = 0, hs_seen = 0;
    logic [15:0] p_addr = '0;
    logic p_last = 1'b0, p_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.addr_valid && p_stall) begin
            chk("hold_addr", 32'(bus.addr_out), 32'(p_addr));
            chk("hold_last", 32'(bus.addr_last), 32'(p_last));
        end
        p_stall = bus.addr_valid && !bus.addr_ready;
        p_addr  = bus.addr_out;
        p_last  = bus.addr_last;
        if (bus.addr_valid && bus.addr_ready) begin
            hs_seen++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_addr: got %0h expected none", bus.addr_out);
            end else begin
                e = q.pop_front();
                chk("addr", 32'(bus.addr_out), 32'(e.a));
                chk("last", 32'(bus.addr_last), 32'(e.l));
            end
        end
    end

    task automatic push_exp(input vec_t v);
        exp_t e;
        for (int y = 0; y < int'(v.ym); y++)
            for (int x = 0; x < int'(v.xm); x++) begin
                e.a = v.off + 16'(x) * v.xs + 16'(y) * v.ys;
                e.l = (x == int'(v.xm) - 1) && (y == int'(v.ym) - 1);
                q.push_back(e);
            end
    endtask

    task automatic launch(input vec_t v, input logic ab);
        @(posedge clk); #1;
        bus.cfg_offset = v.off; bus.cfg_x_max = v.xm; bus.cfg_x_stride = v.xs;
        bus.cfg_y_max = v.ym; bus.cfg_y_stride = v.ys;
        bus.start = 1'b1; bus.abort = ab; bus.addr_ready = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        int c = 0, stalls = 0;
        bit seen = 0;
        push_exp(v);
        hs_seen = 0;
        launch(v, 1'b0);
        while (c < 300 && !seen) begin
            bus.addr_ready = v.mode == 1 ? (c % 3 == 0) : v.mode == 2 ? (c >= 2) : 1'b1;
            if (v.mode == 2 && c < 2) begin
                bus.start = 1'b1; bus.cfg_offset = 16'h5000; bus.cfg_x_max = 16'd7;
            end else bus.start = 1'b0;
            @(negedge clk);
            if (bus.addr_valid && !bus.addr_ready) stalls++;
            if (bus.done) seen = 1;
            @(posedge clk); #1;
            if (!seen) c++;
        end
        bus.start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done");
        end else chk("done_cycle", 32'(c), 32'(v.exp_n + stalls));
        @(negedge clk);
        chk("done_pulse_len", 32'(bus.done), 0);
        chk("busy_after", 32'(bus.busy), 0);
        chk("hs_count", 32'(hs_seen), 32'(v.exp_n));
        chk("queue_empty", 32'(q.size()), 0);
`ifdef ADDR_GEN_SEQ_PERF_EN
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(stalls));
        chk("issue_cnt", 32'(bus.issue_cnt), 32'(v.exp_n));
`endif
    endtask

    initial begin
        vecs[0] = '{16'h0100, 16'd3, 16'd2, 16'd2, 16'h0010, 0, 6};
        vecs[1] = '{16'h0100, 16'd3, 16'd2, 16'd2, 16'h0010, 1, 6};
        vecs[2] = '{16'h0200, 16'd0, 16'd5, 16'd3, 16'h0004, 0, 0};
        vecs[3] = '{16'h0300, 16'd4, 16'd1, 16'd0, 16'h0001, 0, 0};
        vecs[4] = '{16'h0400, 16'd1, 16'd9, 16'd1, 16'h0009, 0, 1};
        vecs[5] = '{16'hFFFE, 16'd4, 16'd1, 16'd1, 16'h0000, 0, 4};
        vecs[6] = '{16'h0100, 16'd3, 16'd2, 16'd2, 16'h0010, 2, 6};
        vecs[7] = '{16'h1000, 16'd2, 16'hFFFF, 16'd3, 16'h8000, 1, 6};
        bus.start = 1'b0; bus.abort = 1'b0; bus.addr_ready = 1'b0;
        bus.cfg_offset = '0; bus.cfg_x_max = '0; bus.cfg_x_stride = '0;
        bus.cfg_y_max = '0; bus.cfg_y_stride = '0;
        #2;
        chk("rst_addr", 32'(bus.addr_out), 0);
        chk("rst_valid", 32'(bus.addr_valid), 0);
        chk("rst_last", 32'(bus.addr_last), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        #11 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_job(vecs[i]);

        // abort in the cycle after the second handshake
        push_exp(vecs[0]);
        hs_seen = 0;
        launch(vecs[0], 1'b0);
        bus.addr_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.addr_ready = 1'b0; bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        q.delete();
        @(negedge clk);
        chk("abort_valid", 32'(bus.addr_valid), 0);
        chk("abort_last", 32'(bus.addr_last), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_hs", 32'(hs_seen), 2);
`ifdef ADDR_GEN_SEQ_PERF_EN
        chk("abort_issue", 32'(bus.issue_cnt), 2);
        chk("abort_stall", 32'(bus.stall_cnt), 1);
`endif
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", 32'(bus.done), 0);
            @(negedge clk);
        end
        run_job(vecs[0]);

        // start together with abort in IDLE launches nothing
        launch(vecs[0], 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sa_busy", 32'(bus.busy), 0);
            chk("sa_valid", 32'(bus.addr_valid), 0);
        end

        // asynchronous reset mid-job, off the clock edge
        push_exp(vecs[0]);
        launch(vecs[0], 1'b0);
        bus.addr_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_addr", 32'(bus.addr_out), 0);
        chk("arst_valid", 32'(bus.addr_valid), 0);
        chk("arst_last", 32'(bus.addr_last), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_done", 32'(bus.done), 0);
`ifdef ADDR_GEN_SEQ_PERF_EN
        chk("arst_issue", 32'(bus.issue_cnt), 0);
`endif
        q.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 0);
        run_job(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
